// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-class LCD bus writer:
// FSM state encoding, command constants, 50 MHz timing defaults
// and small helper functions.
package lcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        EXEC
    } lcd_state_e;

    localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

    // Timing defaults for a 50 MHz clock (20 ns period).
    localparam int unsigned LCD_E_SETUP_CYC   = 2;
    localparam int unsigned LCD_E_PULSE_CYC   = 12;
    localparam int unsigned LCD_E_HOLD_CYC    = 2;
    localparam int unsigned LCD_EXEC_CYC      = 2500;
    localparam int unsigned LCD_LONG_EXEC_CYC = 82000;

    // Clear (0x01) and Return Home (0x02/0x03, bit 0 is don't-care)
    // need the long execution time; everything else is short.
    function automatic logic lcd_is_long(input logic       rs,
                                         input logic [7:0] data);
        logic is_clear;
        logic is_home;
        is_clear = (data == LCD_CMD_CLEAR);
        is_home  = (data[7:1] == LCD_CMD_HOME[7:1]);
        return !rs && (is_clear || is_home);
    endfunction

    function automatic int unsigned lcd_max(input int unsigned a,
                                            input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_bus_writer.sv
// Write-only 8-bit parallel bus transmitter for an HD44780-class LCD.
// Ports: clk/rst (async active-high); in_valid/in_ready/in_rs/in_data
// upstream byte handshake; lcd_rs/lcd_rw/lcd_e/lcd_data to the pins;
// busy is high whenever the FSM is not IDLE. All outputs registered.
module lcd_bus_writer
    import lcd_pkg::*;
#(
    parameter int unsigned E_SETUP_CYC   = LCD_E_SETUP_CYC,
    parameter int unsigned E_PULSE_CYC   = LCD_E_PULSE_CYC,
    parameter int unsigned E_HOLD_CYC    = LCD_E_HOLD_CYC,
    parameter int unsigned EXEC_CYC      = LCD_EXEC_CYC,
    parameter int unsigned LONG_EXEC_CYC = LCD_LONG_EXEC_CYC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_rs,
    input  logic [7:0] in_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_data,
    output logic       busy
);

    localparam int unsigned MAX_CYC =
        lcd_max(lcd_max(E_SETUP_CYC, E_PULSE_CYC),
                lcd_max(E_HOLD_CYC,
                        lcd_max(EXEC_CYC, LONG_EXEC_CYC)));

    localparam int unsigned CW = $clog2(MAX_CYC) + 1;

    // Reload values: each state runs until the counter reaches 0,
    // so loading N-1 gives exactly N cycles in that state.
    localparam logic [CW-1:0] SETUP_LD = CW'(E_SETUP_CYC - 1);
    localparam logic [CW-1:0] PULSE_LD = CW'(E_PULSE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(E_HOLD_CYC - 1);
    localparam logic [CW-1:0] EXEC_LD  = CW'(EXEC_CYC - 1);
    localparam logic [CW-1:0] LEXEC_LD = CW'(LONG_EXEC_CYC - 1);

    lcd_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic          long_q;
    logic          in_ready_q;
    logic          busy_q;
    logic          lcd_e_q;
    logic          lcd_rs_q;
    logic [7:0]    lcd_data_q;

    logic [CW-1:0] exec_ld_d;
    logic          cnt_zero;

    assign exec_ld_d = long_q ? LEXEC_LD : EXEC_LD;
    assign cnt_zero  = (cnt_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            long_q     <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            lcd_e_q    <= 1'b0;
            lcd_rs_q   <= 1'b0;
            lcd_data_q <= 8'h00;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // in_ready is high throughout IDLE, so in_valid
                    // alone marks a transfer here.
                    if (in_valid) begin
                        state_q    <= SETUP;
                        cnt_q      <= SETUP_LD;
                        lcd_rs_q   <= in_rs;
                        lcd_data_q <= in_data;
                        long_q     <= lcd_is_long(in_rs, in_data);
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                SETUP: begin
                    if (cnt_zero) begin
                        state_q <= PULSE;
                        cnt_q   <= PULSE_LD;
                        lcd_e_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                PULSE: begin
                    if (cnt_zero) begin
                        state_q <= HOLD;
                        cnt_q   <= HOLD_LD;
                        lcd_e_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt_zero) begin
                        state_q <= EXEC;
                        cnt_q   <= exec_ld_d;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                EXEC: begin
                    if (cnt_zero) begin
                        state_q    <= IDLE;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    cnt_q      <= '0;
                    in_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                    lcd_e_q    <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign lcd_e    = lcd_e_q;
    assign lcd_rs   = lcd_rs_q;
    assign lcd_data = lcd_data_q;
    // The bus is never read back.
    assign lcd_rw   = 1'b0;

endmodule

// File: tb/tb_lcd_bus_writer.sv
// Scoreboard bench for lcd_bus_writer with short timing parameters.
// Stimulus pushes expected transactions; a negedge monitor checks them.
module tb_lcd_bus_writer;

    localparam int unsigned T_SETUP = 2;
    localparam int unsigned T_PULSE = 4;
    localparam int unsigned T_HOLD  = 2;
    localparam int unsigned T_EXEC  = 10;
    localparam int unsigned T_LONG  = 40;
    localparam int SHORT_TOT = 18;
    localparam int LONG_TOT  = 48;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         total;
        int         spacing;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       in_rs;
    logic [7:0] in_data;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [7:0] lcd_data;
    logic       busy;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   expect_abort = 0;

    lcd_bus_writer #(
        .E_SETUP_CYC  (T_SETUP),
        .E_PULSE_CYC  (T_PULSE),
        .E_HOLD_CYC   (T_HOLD),
        .EXEC_CYC     (T_EXEC),
        .LONG_EXEC_CYC(T_LONG)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_rs   (in_rs),
        .in_data (in_data),
        .lcd_rs  (lcd_rs),
        .lcd_rw  (lcd_rw),
        .lcd_e   (lcd_e),
        .lcd_data(lcd_data),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) @%0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    int   cyc = 0;
    int   last_start = 0;
    bit   active = 0;
    bit   prev_busy = 0;
    bit   prev_e = 0;
    bit   held = 1;
    int   n_busy, n_setup, n_pulse, e_rises;
    exp_t cur;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            active    = 0;
            prev_busy = 0;
            prev_e    = 0;
        end else begin
            if (busy && !prev_busy) begin
                if (expect_abort) begin
                    active = 0;
                end else if (sb.size() == 0) begin
                    chk("unexpected_accept", 1, 0);
                    active = 0;
                end else begin
                    cur     = sb[0];
                    active  = 1;
                    n_busy  = 0;
                    n_setup = 0;
                    n_pulse = 0;
                    e_rises = 0;
                    held    = 1;
                    chk("rs_latched", int'(lcd_rs), int'(cur.rs));
                    chk("data_latched", int'(lcd_data), int'(cur.data));
                    if (cur.spacing != 0)
                        chk("accept_spacing", cyc - last_start,
                            cur.spacing);
                end
                last_start = cyc;
            end
            if (busy && active) begin
                n_busy++;
                if (lcd_e) begin
                    n_pulse++;
                    if (!prev_e) e_rises++;
                    if (lcd_data != cur.data || lcd_rs != cur.rs)
                        held = 0;
                end else if (n_pulse == 0) begin
                    n_setup++;
                end
            end
            if (!busy && prev_busy && active) begin
                void'(sb.pop_front());
                chk("setup_cycles", n_setup, T_SETUP);
                chk("pulse_cycles", n_pulse, T_PULSE);
                chk("e_rises", e_rises, 1);
                chk("busy_cycles", n_busy, cur.total);
                chk("stable_during_e", int'(held), 1);
                chk("data_held_idle", int'(lcd_data), int'(cur.data));
                chk("ready_after", int'(in_ready), 1);
                active = 0;
            end
            prev_busy = busy;
            prev_e    = lcd_e;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_accept(output bit ok);
        bit rdy;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic push(input logic rs, input logic [7:0] d,
                        input int tot, input int sp);
        exp_t e;
        e.rs      = rs;
        e.data    = d;
        e.total   = tot;
        e.spacing = sp;
        sb.push_back(e);
    endtask

    task automatic write1(input logic rs, input logic [7:0] d,
                          input int tot);
        bit ok;
        in_valid = 1'b1;
        in_rs    = rs;
        in_data  = d;
        push(rs, d, tot, 0);
        wait_accept(ok);
        in_valid = 1'b0;
        in_data  = 8'hA5;
        in_rs    = ~rs;
    endtask

    task automatic stream_next(input logic rs, input logic [7:0] d,
                               input int sp);
        bit ok;
        in_rs   = rs;
        in_data = d;
        push(rs, d, SHORT_TOT, sp);
        wait_accept(ok);
        // Garbage on the inputs while busy must be ignored.
        in_rs   = 1'b1;
        in_data = 8'hFF;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, int'(in_ready), 1);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_lcd_e"}, int'(lcd_e), 0);
        chk({tag, "_lcd_rs"}, int'(lcd_rs), 0);
        chk({tag, "_lcd_rw"}, int'(lcd_rw), 0);
        chk({tag, "_lcd_data"}, int'(lcd_data), 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            if (sb.size() == 0 && in_ready && !active) break;
            @(posedge clk);
            #1;
        end
        chk("drain_queue_empty", sb.size(), 0);
    endtask

    initial begin
        bit ok;
        bit seen_e;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_rs    = 1'b0;
        in_data  = 8'h00;

        // 1. reset
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs("reset");
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_reset_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;

        // 2. single data write
        write1(1'b1, 8'h41, SHORT_TOT);
        drain();

        // 3. long commands
        write1(1'b0, 8'h01, LONG_TOT);
        drain();
        write1(1'b0, 8'h02, LONG_TOT);
        drain();
        write1(1'b0, 8'h03, LONG_TOT);
        drain();

        // 4. short commands, and data 0x01 (not long)
        write1(1'b0, 8'h00, SHORT_TOT);
        drain();
        write1(1'b0, 8'h04, SHORT_TOT);
        drain();
        write1(1'b0, 8'h38, SHORT_TOT);
        drain();
        write1(1'b1, 8'h01, SHORT_TOT);
        drain();

        // 5. back-to-back stream with in_valid held
        in_valid = 1'b1;
        stream_next(1'b0, 8'h38, 0);
        stream_next(1'b0, 8'h0C, SHORT_TOT + 1);
        stream_next(1'b0, 8'h06, SHORT_TOT + 1);
        in_valid = 1'b0;
        drain();

        // 6. reset during PULSE
        expect_abort = 1;
        in_valid = 1'b1;
        in_rs    = 1'b1;
        in_data  = 8'h55;
        wait_accept(ok);
        in_valid = 1'b0;
        seen_e = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #3;
            if (lcd_e) begin
                seen_e = 1;
                break;
            end
        end
        chk("pulse_reached", int'(seen_e), 1);
        rst = 1'b1;
        #1;
        chk("async_e_drop", int'(lcd_e), 0);
        chk("async_busy_drop", int'(busy), 0);
        chk("async_ready", int'(in_ready), 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        expect_abort = 0;
        @(negedge clk);
        chk("rst2_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        write1(1'b0, 8'h80, SHORT_TOT);
        drain();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
